// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS receive channel: symbol/data widths,
// the four DVI control tokens and the alignment FSM state encoding.
package tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: classifies a 10-bit symbol as a control
// token (with its c1/c0 pair) and undoes the XOR/XNOR + inversion data coding.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0]  sym,
  output logic              is_ctrl,
  output logic [1:0]        c,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] dataBits;

  always_comb begin
    is_ctrl = 1'b1;
    c       = 2'b00;
    case (sym)
      CTRL_TOKEN_00: c = 2'b00;
      CTRL_TOKEN_01: c = 2'b01;
      CTRL_TOKEN_10: c = 2'b10;
      CTRL_TOKEN_11: c = 2'b11;
      default:       is_ctrl = 1'b0;
    endcase
  end

  // Bit 9 flags a transmitted inversion, bit 8 selects XOR (1) or XNOR (0) chaining.
  always_comb begin
    dataBits = sym[9] ? ~sym[DATA_W-1:0] : sym[DATA_W-1:0];
    data     = '0;
    data[0]  = dataBits[0];
    for (int i = 1; i < DATA_W; i++) begin
      data[i] = sym[8] ? (dataBits[i] ^ dataBits[i-1]) : ~(dataBits[i] ^ dataBits[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit-slip alignment search on control-token runs,
// lock supervision, and a two-stage symbol register / decoded output pipeline.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SYM_W-1:0]  din,
  output logic [DATA_W-1:0] dout,
  output logic              de,
  output logic              c0,
  output logic              c1,
  output logic              locked,
  output logic [3:0]        offset
);

  localparam int TMO_LIMIT = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int RUN_W     = $clog2(CTRL_RUN) + 1;
  localparam int TMO_W     = $clog2(TMO_LIMIT) + 1;

  logic [SYM_W-1:0]   prevWord_q;
  logic [SYM_W-1:0]   sym_q;
  logic [2*SYM_W-1:0] wordPair;
  logic [SYM_W-1:0]   window;

  state_t             state_q, state_d;
  logic [3:0]         offset_q, offset_d;
  logic [RUN_W-1:0]   runCnt_q, runCnt_d, runInc;
  logic [TMO_W-1:0]   tmoCnt_q, tmoCnt_d, tmoInc;
  logic [1:0]         settleCnt_q, settleCnt_d;

  logic [DATA_W-1:0]  dout_q;
  logic               de_q, c0_q, c1_q;

  logic               isCtrl;
  logic [1:0]         ctrlBits;
  logic [DATA_W-1:0]  dataBits;

  // Bit 0 of the older word is the earliest bit, so offset 0 selects prev exactly.
  assign wordPair = {din, prevWord_q};
  assign window   = wordPair[offset_q +: SYM_W];

  tmds_symbol_decode uDecode (
    .sym     (sym_q),
    .is_ctrl (isCtrl),
    .c       (ctrlBits),
    .data    (dataBits)
  );

  assign runInc = (runCnt_q == '1) ? runCnt_q : runCnt_q + 1'b1;
  assign tmoInc = (tmoCnt_q == '1) ? tmoCnt_q : tmoCnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    runCnt_d    = runCnt_q;
    tmoCnt_d    = tmoCnt_q;
    settleCnt_d = settleCnt_q;
    case (state_q)
      SEARCH: begin
        tmoCnt_d = tmoInc;
        if (settleCnt_q != 2'd0) begin
          settleCnt_d = settleCnt_q - 2'd1;
          runCnt_d    = '0;
        end else begin
          runCnt_d = isCtrl ? runInc : '0;
        end
        // A completed run takes priority over a timeout landing on the same cycle.
        if (settleCnt_q == 2'd0 && isCtrl && runInc == RUN_W'(CTRL_RUN)) begin
          state_d  = LOCKED;
          runCnt_d = '0;
          tmoCnt_d = '0;
        end else if (tmoInc == TMO_W'(SEARCH_TIMEOUT)) begin
          offset_d    = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          runCnt_d    = '0;
          tmoCnt_d    = '0;
          settleCnt_d = 2'd2;
        end
      end
      LOCKED: begin
        tmoCnt_d = isCtrl ? '0 : tmoInc;
        if (!isCtrl && tmoInc == TMO_W'(LOSS_TIMEOUT)) begin
          state_d  = SEARCH;
          runCnt_d = '0;
          tmoCnt_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prevWord_q  <= '0;
      sym_q       <= '0;
      state_q     <= SEARCH;
      offset_q    <= '0;
      runCnt_q    <= '0;
      tmoCnt_q    <= '0;
      settleCnt_q <= '0;
    end else begin
      prevWord_q  <= din;
      sym_q       <= window;
      state_q     <= state_d;
      offset_q    <= offset_d;
      runCnt_q    <= runCnt_d;
      tmoCnt_q    <= tmoCnt_d;
      settleCnt_q <= settleCnt_d;
    end
  end

  // Control bits persist through data periods so hsync/vsync stay stable.
  always_ff @(posedge clk) begin
    if (rst || state_q != LOCKED) begin
      dout_q <= '0;
      de_q   <= 1'b0;
      c0_q   <= 1'b0;
      c1_q   <= 1'b0;
    end else if (isCtrl) begin
      dout_q <= '0;
      de_q   <= 1'b0;
      c0_q   <= ctrlBits[0];
      c1_q   <= ctrlBits[1];
    end else begin
      dout_q <= dataBits;
      de_q   <= 1'b1;
    end
  end

  assign dout   = dout_q;
  assign de     = de_q;
  assign c0     = c0_q;
  assign c1     = c1_q;
  assign locked = (state_q == LOCKED);
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: alignment search, lock/loss timing,
// token and data decode tables, full 8-bit sweep through a reference encoder.
module tb_tmds_channel_decoder;

  localparam int LOSS = 64;
  localparam int NV   = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic [7:0] dout;
  logic       de, c0, c1, locked;
  logic [3:0] offset;

  int         nChecks = 0;
  int         nFails  = 0;
  int         rot     = 0;
  logic [9:0] prevW   = '0;
  int         encCnt  = 0;
  logic       histD[3];
  logic [7:0] histV[3];
  int         calls;

  typedef struct {
    logic [9:0] word;
    logic       expDe;
    logic [7:0] expDout;
    logic [1:0] expC;
  } vecT;

  vecT vecs[NV];

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .CTRL_RUN       (8),
    .SEARCH_TIMEOUT (16),
    .LOSS_TIMEOUT   (LOSS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .dout   (dout),
    .de     (de),
    .c0     (c0),
    .c1     (c1),
    .locked (locked),
    .offset (offset)
  );

  // Transmit one word, delayed by 'rot' bits relative to the deserializer framing.
  task automatic applyStimulus(input logic [9:0] w);
    logic [19:0] pair;
    pair  = {w, prevW};
    din   = 10'(pair >> (10 - rot));
    prevW = w;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " dout"}, 32'(dout), 32'h0);
    checkOutput({tag, " de"}, 32'(de), 32'h0);
    checkOutput({tag, " c"}, 32'({c1, c0}), 32'h0);
    checkOutput({tag, " locked"}, 32'(locked), 32'h0);
    checkOutput({tag, " offset"}, 32'(offset), 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(10'h000);
    applyStimulus(10'h000);
    checkIdle("reset");
    rst   = 1'b0;
    prevW = '0;
  endtask

  // Send a word and check the data word that entered two calls earlier.
  task automatic pushWord(input logic [9:0] w, input logic isD, input logic [7:0] v);
    applyStimulus(w);
    histD[2] = histD[1];  histV[2] = histV[1];
    histD[1] = histD[0];  histV[1] = histV[0];
    histD[0] = isD;       histV[0] = v;
    if (histD[2]) begin
      checkOutput($sformatf("sweep de %0h", histV[2]), 32'(de), 32'h1);
      checkOutput($sformatf("sweep dout %0h", histV[2]), 32'(dout), 32'(histV[2]));
    end
  endtask

  // Reference DVI TMDS encoder with running disparity held in encCnt.
  task automatic encodeWord(input logic [7:0] dat, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(dat);
    qm    = '0;
    qm[0] = dat[0];
    if (n1d > 4 || (n1d == 4 && dat[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ dat[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ dat[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (encCnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8] == 1'b0) encCnt += n0q - n1q;
      else               encCnt += n1q - n0q;
    end else if ((encCnt > 0 && n1q > n0q) || (encCnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      encCnt += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      encCnt += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  initial begin
    logic [9:0] enc;
    vecs[0]  = '{10'h354, 1'b0, 8'h00, 2'b00};
    vecs[1]  = '{10'h0AB, 1'b0, 8'h00, 2'b01};
    vecs[2]  = '{10'h154, 1'b0, 8'h00, 2'b10};
    vecs[3]  = '{10'h2AB, 1'b0, 8'h00, 2'b11};
    vecs[4]  = '{10'h1FF, 1'b1, 8'h01, 2'b11};
    vecs[5]  = '{10'h0FF, 1'b1, 8'hFF, 2'b11};
    vecs[6]  = '{10'h155, 1'b1, 8'hFF, 2'b11};
    vecs[7]  = '{10'h10F, 1'b1, 8'h11, 2'b11};
    vecs[8]  = '{10'h00F, 1'b1, 8'hEF, 2'b11};
    vecs[9]  = '{10'h3FF, 1'b1, 8'h00, 2'b11};
    vecs[10] = '{10'h255, 1'b1, 8'h00, 2'b11};
    vecs[11] = '{10'h0AB, 1'b0, 8'h00, 2'b01};
    vecs[12] = '{10'h100, 1'b1, 8'h00, 2'b01};

    rst = 1'b1;
    din = '0;
    doReset();

    // Aligned token run: lock lands exactly on the tenth word.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(10'h354);
      if (k == 8) checkOutput("aligned locked early", 32'(locked), 32'h0);
      if (k == 9) checkOutput("aligned locked", 32'(locked), 32'h1);
    end
    applyStimulus(10'h100);
    applyStimulus(10'h354);
    checkOutput("aligned token de", 32'(de), 32'h0);
    applyStimulus(10'h354);
    checkOutput("aligned data de", 32'(de), 32'h1);
    checkOutput("aligned data dout", 32'(dout), 32'h0);

    for (int i = 0; i < NV + 2; i++) begin
      applyStimulus(i < NV ? vecs[i].word : 10'h354);
      if (i >= 2) begin
        checkOutput($sformatf("vec%0d de", i - 2), 32'(de), 32'(vecs[i-2].expDe));
        checkOutput($sformatf("vec%0d dout", i - 2), 32'(dout), 32'(vecs[i-2].expDout));
        checkOutput($sformatf("vec%0d c", i - 2), 32'({c1, c0}), 32'(vecs[i-2].expC));
      end
    end

    for (int i = 0; i < 3; i++) histD[i] = 1'b0;
    for (int v = 0; v < 256; v++) begin
      if (v % 32 == 0) begin
        encCnt = 0;
        pushWord(10'h354, 1'b0, 8'h00);
      end
      encodeWord(8'(v), enc);
      pushWord(enc, 1'b1, 8'(v));
    end
    pushWord(10'h354, 1'b0, 8'h00);
    pushWord(10'h354, 1'b0, 8'h00);
    checkOutput("sweep still locked", 32'(locked), 32'h1);

    // Data only: lock drops after LOSS cycles of no tokens, outputs blank next.
    for (int j = 1; j <= LOSS + 3; j++) begin
      applyStimulus(10'h100);
      if (j == LOSS + 1) checkOutput("loss locked held", 32'(locked), 32'h1);
      if (j == LOSS + 2) begin
        checkOutput("loss locked dropped", 32'(locked), 32'h0);
        checkOutput("loss last de", 32'(de), 32'h1);
      end
      if (j == LOSS + 3) begin
        checkOutput("loss de", 32'(de), 32'h0);
        checkOutput("loss dout", 32'(dout), 32'h0);
        checkOutput("loss offset kept", 32'(offset), 32'h0);
      end
    end

    // Stream delayed by 3 bits: lines of 12 x 0x0AB then 30 x 0x100, phased
    // so the token burst falls inside the offset-3 dwell.
    doReset();
    rot = 3;
    for (int k = 0; k <= 150; k++) begin
      applyStimulus(((k + 36) % 42 < 12) ? 10'h0AB : 10'h100);
      if (k == 14)  checkOutput("rot offset0", 32'(offset), 32'd0);
      if (k == 15)  checkOutput("rot offset1", 32'(offset), 32'd1);
      if (k == 31)  checkOutput("rot offset2", 32'(offset), 32'd2);
      if (k == 47)  checkOutput("rot offset3", 32'(offset), 32'd3);
      if (k == 56)  checkOutput("rot locked early", 32'(locked), 32'h0);
      if (k == 57)  checkOutput("rot locked", 32'(locked), 32'h1);
      if (k == 58) begin
        checkOutput("rot blank de", 32'(de), 32'h0);
        checkOutput("rot blank c", 32'({c1, c0}), 32'h1);
      end
      if (k == 62) begin
        checkOutput("rot data de", 32'(de), 32'h1);
        checkOutput("rot data dout", 32'(dout), 32'h0);
        checkOutput("rot data c hold", 32'({c1, c0}), 32'h1);
      end
    end
    checkOutput("rot offset stays", 32'(offset), 32'd3);
    checkOutput("rot lock stays", 32'(locked), 32'h1);

    // Lock at offset 7, then a single-cycle reset must clear everything.
    doReset();
    rot = 7;
    for (int k = 0; k < 400 && !locked; k++) applyStimulus(10'h354);
    checkOutput("off7 locked", 32'(locked), 32'h1);
    checkOutput("off7 offset", 32'(offset), 32'd7);
    applyStimulus(10'h354);
    rst = 1'b1;
    applyStimulus(10'h354);
    checkIdle("pulse");
    rst   = 1'b0;
    rot   = 0;
    calls = 0;
    for (int k = 0; k < 40 && !locked; k++) begin
      applyStimulus(10'h354);
      calls++;
    end
    checkOutput("relock locked", 32'(locked), 32'h1);
    checkOutput("relock calls", 32'(calls), 32'd10);
    checkOutput("relock offset", 32'(offset), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
